// File: rtl/syn_fifo.sv
// Single-clock FIFO with registered read data, occupancy counter and
// flags decoded from that counter.
module syn_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic                  full_o,
   output logic                  emty_o,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam int            ADDR_W   = $clog2(DEPTH);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]     wr_ptr;
   logic [ADDR_W-1:0]     rd_ptr;
   logic [ADDR_W:0]       count;
   logic                  wr_ok;
   logic                  rd_ok;

   // Flags come straight from the registered count, so a write while full
   // or a read while empty is filtered out before it touches any state.
   assign full_o = (count == FULL_CNT);
   assign emty_o = (count == '0);
   assign wr_ok  = wr_en & ~full_o;
   assign rd_ok  = rd_en & ~emty_o;

   // Storage is deliberately left out of reset; only written entries are read.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         data_out <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         // The read samples mem before this edge's write lands, so a
         // simultaneous access always returns the pre-existing oldest word.
         if (rd_ok) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_syn_fifo.sv
// Directed bench for syn_fifo: a queue model predicts data_out and flags
// for every cycle of a linear stimulus sequence.
module tb_syn_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data_in;
   logic       wr_en;
   logic       rd_en;
   logic       full_o;
   logic       emty_o;
   logic [7:0] data_out;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] sb[$];
   logic [7:0] exp_dout;

   syn_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .full_o   (full_o),
      .emty_o   (emty_o),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
      chk({tag, ".emty_o"},   32'(emty_o),   32'(sb.size() == 0));
      chk({tag, ".full_o"},   32'(full_o),   32'(sb.size() == 8));
   endtask

   // One clock cycle of stimulus; the model is updated with the read first so
   // a simultaneous write is never visible to the read in the same cycle.
   task automatic cyc(input logic w, input logic r, input logic [7:0] d, input string tag);
      bit wok, rok;
      wok = w && (sb.size() < 8);
      rok = r && (sb.size() > 0);
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      if (rok) exp_dout = sb.pop_front();
      if (wok) sb.push_back(d);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk_all(tag);
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
      exp_dout = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_all("idle");

      // Fill, then overflow attempt
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(i), "fill");
      cyc(1'b1, 1'b0, 8'hFF, "overflow");

      // Drain, then underflow attempt
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h00, "drain");
      cyc(1'b0, 1'b1, 8'h00, "underflow");

      // Pointer wrap-around
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(100 + i), "wrap_wr");
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h00, "wrap_rd");

      // Simultaneous access with 4 entries held
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(10 + i), "sim_pre");
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'(20 + i), "sim_both");
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h00, "sim_drain");

      // Simultaneous access while empty: write only
      cyc(1'b1, 1'b1, 8'h33, "sim_empty");
      cyc(1'b0, 1'b1, 8'h00, "sim_empty_rd");

      // Simultaneous access while full: read only
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(200 + i), "refill");
      cyc(1'b1, 1'b1, 8'hEE, "sim_full");
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'h00, "sim_full_drain");

      // Mid-operation asynchronous reset
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(40 + i), "pre_rst");
      #3;
      rst_n = 1'b0;
      sb.delete();
      exp_dout = '0;
      #1;
      chk_all("async_rst");
      wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hAA;
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0;
      chk_all("rst_held");
      rst_n = 1'b1;
      cyc(1'b1, 1'b0, 8'h55, "post_rst_wr");
      cyc(1'b0, 1'b1, 8'h00, "post_rst_rd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
